wt_dcache_miss_arb: RTL and testbench
=====================================

// Module: wt_dcache_miss_arb
// PURPOSE
// - Shares the single miss-unit request channel between NumPorts requesters (MMU, load ctrls, wbuffer).
// - Two-class priority: high-prio ports beat low-prio ports; round-robin inside each class; starvation counters.
// - Registers the winning request and holds it stable until miss_ack_i; gates new grants during flush.
// - Sits between the per-port controllers and the dcache miss unit.
// PARAMETERS
// - CVA6Cfg      cva6_cfg_empty  core configuration
// - NumPorts     4               number of requesters (index NumPorts-1 = write buffer)
// - StarveLimit  15              wait cycles after which a requesting port is force-granted (>=1)
// PORTS
// - clk_i          in   1                   clock
// - rst_i          in   1                   asynchronous reset, active-high
// - flush_i        in   1                   block new grants while high
// - flush_idle_o   out  1                   flush_i high and no grant outstanding
// - req_prio_i     in   NumPorts            1 = high-priority class, per port
// - req_i          in   NumPorts            per-port miss request, held until req_ack_o
// - req_data_i     in   NumPorts x miss_req_t  per-port payload (paddr, size, we, nc, id, wdata, wuser)
// - req_ack_o      out  NumPorts            one-hot, 1-cycle pulse, equals miss_ack_i on the granted port
// - miss_req_o     out  1                   request to miss unit
// - miss_ack_i     in   1                   miss unit accepts miss_data_o
// - miss_data_o    out  miss_req_t          registered payload of the granted port
// - miss_port_o    out  $clog2(NumPorts)    index of the granted port
// BEHAVIOUR
// - Reset (async, rst_i=1): state IDLE, miss_req_o=0, miss_data_o='0, miss_port_o=0, req_ack_o=0,
//   flush_idle_o=0, rr_ptr_hi=rr_ptr_lo=0, all wait counters 0; asserting rst_i mid-grant drops it immediately.
// - FSM IDLE: if !flush_i and |req_i, select winner, latch payload and index -> GRANT (miss_req_o=1 next cycle).
// - FSM GRANT: miss_req_o=1, outputs frozen; on miss_ack_i: req_ack_o[miss_port_o]=1 same cycle -> IDLE.
// - Throughput: at most one grant per 2 cycles (ack cycle returns to IDLE; arbitration on the following cycle).
// - Selection order: (1) starved ports (counter==StarveLimit), lowest index first; (2) high-prio
//   requesters, round-robin from rr_ptr_hi; (3) low-prio requesters, round-robin from rr_ptr_lo.
// - RR pointer of the winning class <= winner+1, wraps NumPorts-1 -> 0; the other pointer is unchanged.
// - Wait counter[k]: +1 per cycle req_i[k]=1 and port k not granted, saturates at StarveLimit;
//   cleared when k is granted or req_i[k]=0.
// - flush_i: no transition IDLE->GRANT; outstanding grant completes normally; flush_idle_o=flush_i & (state==IDLE).
// - Simultaneous flush_i rise and arbitration in IDLE: flush wins, no grant issued.
// - req_i[k] deasserted while k granted: protocol violation (assertion); output unaffected, grant completes.
// - miss_ack_i while IDLE: ignored, req_ack_o stays 0 (assertion flags it).
// CONFIGURATION
// - WT_DCACHE_MISS_ARB_PERF_EN defined: adds outputs grant_cnt_o [NumPorts][31:0] (grants per port,
//   wrap on overflow) and starve_cnt_o [31:0] (grants issued via rule (1)); cleared on reset.
// - Undefined: counters and ports absent; arbitration behaviour identical.
// STRUCTURE
// - wt_cache_pkg: miss_req_t packed struct, arb_state_e {IDLE, GRANT}.
// - Sub-module wt_dcache_rr_pick: masked round-robin picker (req vector, ptr -> one-hot + index), instantiated per class.
// - Wait counters and FSM in this module.
// TESTING
// - Reset: rst_i=1 during GRANT of port 2 -> miss_req_o=0 within same cycle, all counters 0 after release.
// - Prio: req_i=4'b1001, req_prio_i=4'b0111 -> port 0 granted first, port 3 after its ack.
// - RR: ports 0,1,2 high-prio requesting continuously, ack after 1 cycle -> grant order 0,1,2,0,1,2.
// - Starve: StarveLimit=3, ports 0,1 high, port 3 low always requesting -> port 3 granted once its counter reaches 3.
// - Flush: flush_i=1 during GRANT -> grant completes on ack, flush_idle_o=1 next cycle, no new grant while flush_i.
// - Hold: miss_ack_i delayed 10 cycles -> miss_data_o/miss_port_o stable, req_ack_o pulse exactly 1 cycle.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through dcache miss path: miss request payload, arbiter states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package wt_cache_pkg;

  // Minimal core configuration record; the arbiter only carries it through.
  typedef struct packed {
    logic [31:0] xlen;
    logic [31:0] plen;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  typedef struct packed {
    logic [55:0] paddr;
    logic [2:0]  size;
    logic        we;
    logic        nc;
    logic [3:0]  id;
    logic [63:0] wdata;
    logic [7:0]  wuser;
  } miss_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Next round-robin position after idx, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/wt_dcache_rr_pick.sv
// Masked round-robin picker: first set request at or after ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module wt_dcache_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // Scan N positions starting at ptr; the first requester found wins.
  always_comb begin
    int unsigned c;
    c      = 0;
    vld    = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = 32'(ptr) + i;
      if (c >= N) c = c - N;
      if (!vld && req[IW'(c)]) begin
        vld             = 1'b1;
        onehot[IW'(c)]  = 1'b1;
        idx             = IW'(c);
      end
    end
  end

endmodule

// File: rtl/wt_dcache_miss_arb.sv
// Arbitrates NumPorts requesters onto the single miss-unit channel (starved > high-prio RR > low-prio RR).
// Latency: grant registered 1 cycle after arbitration; req_ack_o is combinational with miss_ack_i; max 1 grant / 2 cycles.
// Backpressure: granted payload held stable until miss_ack_i; flush_i blocks new grants. Optional WT_DCACHE_MISS_ARB_PERF_EN adds counters.
module wt_dcache_miss_arb
  import wt_cache_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg     = cva6_cfg_empty,
  parameter int unsigned NumPorts    = 4,
  parameter int unsigned StarveLimit = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  output logic                          flush_idle_o,
  input  logic [NumPorts-1:0]           req_prio_i,
  input  logic [NumPorts-1:0]           req_i,
  input  miss_req_t [NumPorts-1:0]      req_data_i,
  output logic [NumPorts-1:0]           req_ack_o,
  output logic                          miss_req_o,
  input  logic                          miss_ack_i,
  output miss_req_t                     miss_data_o,
  output logic [$clog2(NumPorts)-1:0]   miss_port_o
`ifdef WT_DCACHE_MISS_ARB_PERF_EN
  ,
  output logic [NumPorts-1:0][31:0]     grant_cnt_o,
  output logic [31:0]                   starve_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(NumPorts);
  localparam int unsigned CW = $clog2(StarveLimit + 1);

  arb_state_e          state_q;
  logic [PW-1:0]       rr_ptr_hi_q, rr_ptr_lo_q;
  logic [CW-1:0]       wait_cnt_q [NumPorts];

  logic [NumPorts-1:0] starved, st_oh, hi_req, lo_req, hi_oh, lo_oh, win_oh, grant_hold;
  logic [PW-1:0]       st_idx, hi_idx, lo_idx, win_idx, next_ptr;
  logic                hi_vld, lo_vld, arb_go, win_prio;

  assign hi_req = req_i & req_prio_i;
  assign lo_req = req_i & ~req_prio_i;
  assign st_oh  = starved & (~starved + 1'b1);

  wt_dcache_rr_pick #(.N(NumPorts), .IW(PW)) i_pick_hi (
    .req    (hi_req),
    .ptr    (rr_ptr_hi_q),
    .vld    (hi_vld),
    .onehot (hi_oh),
    .idx    (hi_idx)
  );

  wt_dcache_rr_pick #(.N(NumPorts), .IW(PW)) i_pick_lo (
    .req    (lo_req),
    .ptr    (rr_ptr_lo_q),
    .vld    (lo_vld),
    .onehot (lo_oh),
    .idx    (lo_idx)
  );

  // Ports that have waited StarveLimit cycles; the lowest such index is picked first.
  always_comb begin
    starved = '0;
    st_idx  = '0;
    for (int k = 0; k < NumPorts; k++) begin
      starved[k] = req_i[k] && (wait_cnt_q[k] == CW'(StarveLimit));
    end
    for (int k = NumPorts - 1; k >= 0; k--) begin
      if (starved[k]) st_idx = PW'(k);
    end
  end

  // Winner: starved ports, then high class, then low class (lo_vld implied when nothing else requests).
  always_comb begin
    win_oh  = lo_oh;
    win_idx = lo_idx;
    if (|starved) begin
      win_oh  = st_oh;
      win_idx = st_idx;
    end else if (hi_vld) begin
      win_oh  = hi_oh;
      win_idx = hi_idx;
    end
  end

  assign win_prio     = req_prio_i[win_idx];
  assign next_ptr     = PW'(wrap_inc(32'(win_idx), NumPorts));
  assign arb_go       = (state_q == IDLE) && !flush_i && (|req_i) && (lo_vld || hi_vld);
  assign grant_hold   = (state_q == GRANT) ? (NumPorts'(1) << miss_port_o) : '0;
  assign req_ack_o    = miss_ack_i ? grant_hold : '0;
  assign flush_idle_o = flush_i && (state_q == IDLE) && !rst_i;

  // Grant FSM: latch the winner's payload and hold it until the miss unit acknowledges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      miss_req_o  <= 1'b0;
      miss_data_o <= '0;
      miss_port_o <= '0;
      rr_ptr_hi_q <= '0;
      rr_ptr_lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_go) begin
            state_q     <= GRANT;
            miss_req_o  <= 1'b1;
            miss_data_o <= req_data_i[win_idx];
            miss_port_o <= win_idx;
            if (win_prio) rr_ptr_hi_q <= next_ptr;
            else          rr_ptr_lo_q <= next_ptr;
          end
        end
        GRANT: begin
          if (miss_ack_i) begin
            state_q    <= IDLE;
            miss_req_o <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-port wait age: grows while waiting, pinned at StarveLimit, cleared on grant or release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumPorts; k++) wait_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NumPorts; k++) begin
        if (!req_i[k] || (arb_go && win_oh[k]) || grant_hold[k]) begin
          wait_cnt_q[k] <= '0;
        end else if (wait_cnt_q[k] != CW'(StarveLimit)) begin
          wait_cnt_q[k] <= wait_cnt_q[k] + 1'b1;
        end
      end
    end
  end

`ifdef WT_DCACHE_MISS_ARB_PERF_EN
  // Grant statistics, counted when a grant is issued; wrap on overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_cnt_o  <= '0;
      starve_cnt_o <= '0;
    end else if (arb_go) begin
      grant_cnt_o[win_idx] <= grant_cnt_o[win_idx] + 32'd1;
      if (|starved) starve_cnt_o <= starve_cnt_o + 32'd1;
    end
  end
`endif

  // Requesters hold their request until acknowledged; the miss unit only acks an outstanding grant.
  assert property (@(posedge clk_i) disable iff (rst_i) (state_q == GRANT) |-> req_i[miss_port_o]);
  assert property (@(posedge clk_i) disable iff (rst_i) miss_ack_i |-> (state_q == GRANT));

endmodule

// File: tb/tb_wt_dcache_miss_arb.sv
// Self-checking bench for wt_dcache_miss_arb (StarveLimit=3).
// Expected grants are queued as stimulus is applied and compared when the DUT grants.
// Requesters drop or keep their request on the cycle after the acknowledge.
module tb_wt_dcache_miss_arb;
  import wt_cache_pkg::*;

  localparam int NP        = 4;
  localparam int M_KEEP    = 0;
  localparam int M_GRANTED = 1;
  localparam int M_ALL     = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 flush_i = 1'b1;
  logic                 flush_idle_o;
  logic [NP-1:0]        req_prio_i = '0;
  logic [NP-1:0]        req_i = '0;
  miss_req_t [NP-1:0]   req_data_i;
  logic [NP-1:0]        req_ack_o;
  logic                 miss_req_o;
  logic                 miss_ack_i = 1'b0;
  miss_req_t            miss_data_o;
  logic [1:0]           miss_port_o;

  wt_dcache_miss_arb #(.NumPorts(NP), .StarveLimit(3)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .flush_idle_o (flush_idle_o),
    .req_prio_i   (req_prio_i),
    .req_i        (req_i),
    .req_data_i   (req_data_i),
    .req_ack_o    (req_ack_o),
    .miss_req_o   (miss_req_o),
    .miss_ack_i   (miss_ack_i),
    .miss_data_o  (miss_data_o),
    .miss_port_o  (miss_port_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0] port;
    miss_req_t  data;
  } exp_t;

  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] prio;
    int            win;
  } vec_t;

  exp_t sb_q[$];
  int   seq  [NP];
  int   pend [NP];
  int   total = 0;
  int   bad   = 0;

  function automatic miss_req_t mk(input int p, input int s);
    miss_req_t r;
    r.paddr = 56'h00_1000_0000 + 56'(p) * 56'h100 + 56'(s) * 56'h8;
    r.size  = 3'(s);
    r.we    = 1'(p);
    r.nc    = 1'(s);
    r.id    = 4'(p + 4 * s);
    r.wdata = {32'(32'hA5A5_0000 + p), 32'(s)};
    r.wuser = 8'(p * 16 + s);
    return r;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_port(input int p);
    exp_t e;
    e.port = 2'(p);
    e.data = mk(p, pend[p]);
    pend[p]++;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1; req_i = '0; req_prio_i = '0; flush_i = 1'b0; miss_ack_i = 1'b0;
    for (int p = 0; p < NP; p++) begin
      seq[p] = 0; pend[p] = 0; req_data_i[p] = mk(p, 0);
    end
    sb_q.delete();
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // Requester + miss unit model: acks ack_dly cycles into each grant and scores every grant.
  task automatic run_grants(input int ack_dly, input int mode, input int budget);
    logic [1:0]    cur_port = '0;
    miss_req_t     cur_dat  = '0;
    logic [NP-1:0] exp_ack;
    bit            in_grant = 0, acked = 0, busy = 1;
    int            h = 0, cyc = 0;
    exp_t          e;
    while (busy && cyc < budget) begin
      @(posedge clk_i); #1; cyc++;
      if (acked) begin
        acked = 0;
        seq[cur_port]++;
        req_data_i[cur_port] = mk(int'(cur_port), seq[cur_port]);
        if (sb_q.size() == 0 || mode == M_ALL) req_i = '0;
        else if (mode == M_GRANTED) req_i[cur_port] = 1'b0;
        if (sb_q.size() == 0) busy = 0;
      end
      if (miss_req_o) begin
        if (!in_grant) begin
          in_grant = 1; h = 0; cur_port = miss_port_o; cur_dat = miss_data_o;
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_grant: got port %0d expected none", miss_port_o);
          end else begin
            e = sb_q.pop_front();
            chk("grant_port", 160'(miss_port_o), 160'(e.port));
            chk("grant_data", 160'(miss_data_o), 160'(e.data));
          end
        end else begin
          chk("hold_port", 160'(miss_port_o), 160'(cur_port));
          chk("hold_data", 160'(miss_data_o), 160'(cur_dat));
        end
        miss_ack_i = (h == ack_dly);
        h++;
      end else begin
        if (in_grant) begin
          total++; bad++;
          $display("FAIL grant_dropped: got miss_req_o 0 expected 1");
          in_grant = 0;
        end
        miss_ack_i = 1'b0;
      end
      #1;
      exp_ack = miss_ack_i ? (4'b0001 << cur_port) : 4'b0000;
      chk("req_ack", 160'(req_ack_o), 160'(exp_ack));
      if (miss_ack_i) begin
        in_grant = 0;
        acked    = 1;
      end
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL grant_timeout: got %0d grants pending expected 0", sb_q.size());
    end
    miss_ack_i = 1'b0;
    req_i = '0;
  endtask

  vec_t vt [8];

  initial begin
    vt[0] = '{4'b0001, 4'b0000, 0};
    vt[1] = '{4'b1001, 4'b0111, 0};
    vt[2] = '{4'b1000, 4'b0111, 3};
    vt[3] = '{4'b0110, 4'b0100, 2};
    vt[4] = '{4'b1110, 4'b0000, 1};
    vt[5] = '{4'b1010, 4'b1000, 3};
    vt[6] = '{4'b1111, 4'b1111, 0};
    vt[7] = '{4'b1100, 4'b0010, 2};
    for (int p = 0; p < NP; p++) req_data_i[p] = mk(p, 0);

    // Reset state, with flush_i high to show flush_idle_o is held low during reset.
    @(posedge clk_i); @(posedge clk_i); #1;
    chk("rst_miss_req", 160'(miss_req_o), 160'(0));
    chk("rst_miss_port", 160'(miss_port_o), 160'(0));
    chk("rst_miss_data", 160'(miss_data_o), 160'(0));
    chk("rst_req_ack", 160'(req_ack_o), 160'(0));
    chk("rst_flush_idle", 160'(flush_idle_o), 160'(0));
    rst_i = 1'b0; #1;
    chk("flush_idle_after_rst", 160'(flush_idle_o), 160'(1));
    flush_i = 1'b0; #1;
    chk("flush_idle_low", 160'(flush_idle_o), 160'(0));

    // Single-grant selection table from a fresh reset.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      req_prio_i = vt[i].prio;
      req_i      = vt[i].req;
      exp_port(vt[i].win);
      run_grants(0, M_ALL, 20);
    end

    // High class beats low class; low port served after the ack.
    do_reset();
    req_prio_i = 4'b0111; req_i = 4'b1001;
    exp_port(0); exp_port(3);
    run_grants(0, M_GRANTED, 30);

    // Round robin among three continuous high-prio requesters.
    do_reset();
    req_prio_i = 4'b0111; req_i = 4'b0111;
    exp_port(0); exp_port(1); exp_port(2); exp_port(0); exp_port(1); exp_port(2);
    run_grants(0, M_KEEP, 60);

    // Starvation: low-prio port 3 force-granted once its wait reaches 3.
    do_reset();
    req_prio_i = 4'b0011; req_i = 4'b1011;
    exp_port(0); exp_port(1); exp_port(3); exp_port(0);
    run_grants(0, M_KEEP, 60);

    // Delayed ack: outputs held for 11 cycles, single ack pulse; waiting port then served.
    do_reset();
    req_prio_i = 4'b0000; req_i = 4'b0110;
    exp_port(1); exp_port(2);
    run_grants(10, M_GRANTED, 60);

    // Flush during a grant: grant completes, then no grants until flush drops.
    do_reset();
    req_i = 4'b0010;
    @(posedge clk_i); #1;
    chk("fl_grant", 160'(miss_req_o), 160'(1));
    chk("fl_port", 160'(miss_port_o), 160'(1));
    flush_i = 1'b1; req_i[3] = 1'b1; #1;
    chk("fl_idle_busy", 160'(flush_idle_o), 160'(0));
    @(posedge clk_i); #1;
    chk("fl_held", 160'(miss_req_o), 160'(1));
    miss_ack_i = 1'b1; #1;
    chk("fl_ack", 160'(req_ack_o), 160'(4'b0010));
    @(posedge clk_i); #1;
    miss_ack_i = 1'b0; req_i[1] = 1'b0;
    chk("fl_done", 160'(miss_req_o), 160'(0));
    chk("fl_idle", 160'(flush_idle_o), 160'(1));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      chk("fl_blocked", 160'(miss_req_o), 160'(0));
      chk("fl_idle_hold", 160'(flush_idle_o), 160'(1));
    end
    flush_i = 1'b0; #1;
    chk("fl_idle_clr", 160'(flush_idle_o), 160'(0));
    exp_port(3);
    run_grants(0, M_GRANTED, 20);

    // Flush rising together with a fresh request in IDLE: no grant.
    do_reset();
    flush_i = 1'b1; req_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("flrise_blocked", 160'(miss_req_o), 160'(0));
    end
    flush_i = 1'b0;
    exp_port(0);
    run_grants(0, M_GRANTED, 20);

    // Reset asserted mid-grant drops the grant at once and clears wait counters.
    do_reset();
    req_prio_i = 4'b0100; req_i = 4'b0110;
    @(posedge clk_i); #1;
    chk("mr_grant_port", 160'(miss_port_o), 160'(2));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      chk("mr_held", 160'(miss_req_o), 160'(1));
    end
    rst_i = 1'b1; #1;
    chk("mr_req_drop", 160'(miss_req_o), 160'(0));
    chk("mr_port_clr", 160'(miss_port_o), 160'(0));
    chk("mr_data_clr", 160'(miss_data_o), 160'(0));
    chk("mr_ack_clr", 160'(req_ack_o), 160'(0));
    do_reset();
    req_prio_i = 4'b0001; req_i = 4'b0011;
    exp_port(0); exp_port(1);
    run_grants(0, M_GRANTED, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
